// File: rtl/shake_job_arbiter.sv
// Round-robin arbiter granting one whole SHAKE job at a time to one of NUM_REQ requesters.
// Latency: req sampled in IDLE -> ack/core_start next cycle; data paths are combinational muxes.
// Backpressure: in_ready/core_out_ready pass straight through to the winner; losers see ready=0.
module shake_job_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int W       = 64,
  parameter int L       = 16,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_mode,
  input  logic [NUM_REQ*L-1:0] req_outlen,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   req_done,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ*W-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_last,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic [NUM_REQ-1:0]   out_valid,
  output logic [W-1:0]         out_data,
  input  logic [NUM_REQ-1:0]   out_ready,
  input  logic                 core_idle,
  output logic                 core_start,
  output logic                 core_mode,
  output logic [L-1:0]         core_outlen,
  output logic                 core_in_valid,
  output logic [W-1:0]         core_in_data,
  output logic                 core_in_last,
  input  logic                 core_in_ready,
  input  logic                 core_out_valid,
  input  logic [W-1:0]         core_out_data,
  output logic                 core_out_ready,
  input  logic                 core_done,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic          input_closed;
  logic          pick_vld;
  logic [GW-1:0] pick_id;
  logic          in_busy;

  assign in_busy = (state == ST_BUSY);

  // Round-robin search: first set req at or above rr_ptr, wrapping; scan downward so the nearest wins.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx[GW-1:0];
      end
    end
  end

  // Job FSM: grant capture, launch, run until core_done, then advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      input_closed <= 1'b0;
      core_mode    <= 1'b0;
      core_outlen  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (core_idle && pick_vld) begin
            grant_id    <= pick_id;
            core_mode   <= req_mode[pick_id];
            core_outlen <= req_outlen[pick_id*L +: L];
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          input_closed <= 1'b0;
          state        <= ST_BUSY;
        end
        ST_BUSY: begin
          // Once the last message beat is in, further beats from the winner are refused.
          if (core_in_valid && core_in_ready && core_in_last) input_closed <= 1'b1;
          if (core_done) state <= ST_DONE;
        end
        default: begin
          rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake pulses and data muxing; everything is forced to zero outside the relevant state.
  always_comb begin
    req_ack        = '0;
    req_done       = '0;
    in_ready       = '0;
    out_valid      = '0;
    core_start     = (state == ST_LAUNCH);
    busy           = (state != ST_IDLE);
    core_in_valid  = in_busy & in_valid[grant_id] & ~input_closed;
    core_in_data   = in_busy ? in_data[grant_id*W +: W] : '0;
    core_in_last   = in_busy & in_last[grant_id];
    core_out_ready = in_busy & out_ready[grant_id];
    out_data       = in_busy ? core_out_data : '0;
    if (state == ST_LAUNCH) req_ack[grant_id] = 1'b1;
    if (state == ST_DONE)   req_done[grant_id] = 1'b1;
    if (in_busy) begin
      in_ready[grant_id]  = core_in_ready & ~input_closed;
      out_valid[grant_id] = core_out_valid;
    end
  end

endmodule

// File: tb/tb_shake_job_arbiter.sv
// Randomized job-level bench for shake_job_arbiter: plays requesters and core,
// predicts grants from a round-robin rule and checks every routed signal each cycle.
// All stimulus changes on the falling edge; outputs are checked 1 time unit later.
module tb_shake_job_arbiter;
  localparam int N = 2;
  localparam int W = 64;
  localparam int L = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req, req_mode, req_ack, req_done;
  logic [N*L-1:0] req_outlen;
  logic [N-1:0]   in_valid, in_last, in_ready, out_valid, out_ready;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   out_data;
  logic           core_idle, core_start, core_mode;
  logic [L-1:0]   core_outlen;
  logic           core_in_valid, core_in_last, core_in_ready;
  logic [W-1:0]   core_in_data, core_out_data;
  logic           core_out_valid, core_out_ready, core_done, busy;
  logic [0:0]     grant_id;

  shake_job_arbiter #(.NUM_REQ(N), .W(W), .L(L)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_outlen(req_outlen),
    .req_ack(req_ack), .req_done(req_done), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .core_idle(core_idle), .core_start(core_start),
    .core_mode(core_mode), .core_outlen(core_outlen), .core_in_valid(core_in_valid),
    .core_in_data(core_in_data), .core_in_last(core_in_last), .core_in_ready(core_in_ready),
    .core_out_valid(core_out_valid), .core_out_data(core_out_data),
    .core_out_ready(core_out_ready), .core_done(core_done), .busy(busy), .grant_id(grant_id)
  );

  int checks = 0;
  int passed = 0;
  int exp_ptr = 0;   // model of the round-robin starting point

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference rule: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_start"}, core_start, 0);
    check_eq({tag, "_ack"}, req_ack, 0);
    check_eq({tag, "_done"}, req_done, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_cin_valid"}, core_in_valid, 0);
    check_eq({tag, "_cin_data"}, core_in_data, 0);
    check_eq({tag, "_cin_last"}, core_in_last, 0);
    check_eq({tag, "_cout_ready"}, core_out_ready, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic randomize_side();
    in_data       = {$urandom, $urandom, $urandom, $urandom};
    core_out_data = {$urandom, $urandom};
  endtask

  task automatic run_job(input logic [N-1:0] r, input int idle_dly, input bit abort);
    int g, o, nb, sent, post, nout, got_beats;
    bit closed, xfer;
    logic exp_mode;
    logic [L-1:0] exp_len;
    logic [N-1:0] exp_rdy;
    // core busy elsewhere: requests must wait, stray core_done ignored
    req        = r;
    req_mode   = N'($urandom);
    req_outlen = {$urandom};
    core_idle  = 1'b0;
    for (int i = 0; i < idle_dly; i++) begin
      core_done = 1'($urandom);
      #1 check_quiet("wait");
      @(negedge clk);
    end
    core_done = 1'b0;
    core_idle = 1'b1;
    g = rr_pick(r, exp_ptr);
    o = 1 - g;
    exp_mode = req_mode[g];
    exp_len  = req_outlen[g*L +: L];
    #1 check_eq("pre_launch_busy", busy, 0);
    @(negedge clk);
    // LAUNCH: change requester fields and maybe drop req; the job must not notice
    core_idle  = 1'b0;
    req_mode   = N'($urandom);
    req_outlen = {$urandom};
    req        = N'($urandom);
    #1;
    check_eq("start", core_start, 1);
    check_eq("ack", req_ack, N'(1) << g);
    check_eq("grant_id", grant_id, g);
    check_eq("launch_busy", busy, 1);
    check_eq("launch_cin_valid", core_in_valid, 0);
    @(negedge clk);
    // BUSY input phase
    nb = $urandom_range(1, 4); sent = 0; post = 0; closed = 0;
    for (int c = 0; c < 60 && post < 3; c++) begin
      randomize_side();
      in_valid      = N'($urandom);
      core_in_ready = 1'($urandom);
      out_ready     = N'($urandom);
      core_out_valid = 1'b0;
      if (c >= 20 || closed) begin in_valid[g] = 1'b1; end
      if (c >= 20) core_in_ready = 1'b1;
      in_last    = N'($urandom);
      in_last[g] = (sent == nb - 1);
      if (abort && c == 2) core_done = 1'($urandom);
      #1;
      check_eq("cin_valid", core_in_valid, in_valid[g] & ~closed);
      check_eq("cin_data", core_in_data, in_data[g*W +: W]);
      check_eq("cin_last", core_in_last, in_last[g]);
      exp_rdy = '0; exp_rdy[g] = core_in_ready & ~closed;
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("in_out_valid", out_valid, 0);
      check_eq("mode_hold", core_mode, exp_mode);
      check_eq("outlen_hold", core_outlen, exp_len);
      if (abort && c == 2) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; core_done = 1'b0; in_valid = '0; core_out_valid = 1'b0;
        #1;
        check_quiet("abort");
        check_eq("abort_grant", grant_id, 0);
        check_eq("abort_mode", core_mode, 0);
        check_eq("abort_outlen", core_outlen, 0);
        exp_ptr = 0;
        @(negedge clk);
        #1 check_eq("abort_no_done", req_done, 0);
        @(negedge clk);
        return;
      end
      if (in_valid[g] && core_in_ready && !closed) begin
        sent++;
        if (sent == nb) closed = 1;
      end else if (closed) post++;
      @(negedge clk);
    end
    check_eq("input_closed", closed, 1);
    // BUSY output phase; last digest beat coincides with core_done
    nout = $urandom_range(1, 3); got_beats = 0;
    for (int c = 0; c < 60; c++) begin
      randomize_side();
      core_out_valid = 1'($urandom);
      out_ready      = N'($urandom);
      in_valid[g]    = 1'b1;
      if (c >= 20) begin core_out_valid = 1'b1; out_ready[g] = 1'b1; end
      xfer = core_out_valid & out_ready[g];
      core_done = (got_beats == nout - 1) && xfer;
      #1;
      check_eq("out_valid_g", out_valid[g], core_out_valid);
      check_eq("out_valid_o", out_valid[o], 0);
      check_eq("cout_ready", core_out_ready, out_ready[g]);
      check_eq("out_data", out_data, core_out_data);
      check_eq("closed_cin_valid", core_in_valid, 0);
      check_eq("closed_in_ready", in_ready, 0);
      if (xfer) got_beats++;
      @(negedge clk);
      if (core_done) break;
    end
    check_eq("out_beats", got_beats, nout);
    core_done = 1'b0; core_out_valid = 1'b0; in_valid = '0;
    #1;
    check_eq("req_done", req_done, N'(1) << g);
    check_eq("done_busy", busy, 1);
    check_eq("done_out_data", out_data, 0);
    check_eq("done_cout_ready", core_out_ready, 0);
    exp_ptr = (g + 1) % N;
    @(negedge clk);
    #1 check_quiet("post_idle");
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_mode = '0; req_outlen = '0; in_valid = '0; in_data = '0;
    in_last = '0; out_ready = '0; core_idle = 1'b0; core_in_ready = 1'b0;
    core_out_valid = 1'b0; core_out_data = '0; core_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_quiet("reset");
    check_eq("reset_grant", grant_id, 0);
    check_eq("reset_mode", core_mode, 0);
    check_eq("reset_outlen", core_outlen, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) run_job(2'b11, 0, 0);
    run_job(2'b10, 5, 0);
    run_job(2'b01, 1, 0);
    run_job(2'b11, 0, 1);   // pointer was 1: aborted job belongs to slot 1
    run_job(2'b11, 0, 0);   // reset pointer means slot 0 wins
    for (int j = 0; j < 30; j++) begin
      if (j == 14) begin
        run_job(2'b11, 0, 1);
        run_job(2'b11, 0, 0);
      end else begin
        run_job(N'($urandom_range(1, 3)), $urandom_range(0, 3), 0);
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
